// File: rtl/axi_print_monitor.sv
// +--------------------------------------------------------------------------+
// | Module   : axi_print_monitor                                             |
// | Purpose  : Passive AXI4 write snooper decoding stdout/stderr/EOC writes. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module axi_print_monitor #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] STDERR_ADDR = 32'h2FFF_0000,
  parameter logic [ADDR_W-1:0] STDOUT_ADDR = 32'h2FFF_0004,
  parameter logic [ADDR_W-1:0] EOC_ADDR    = 32'h2C03_0000,
  parameter int                AW_DEPTH    = 8,
  parameter int                CHAR_DEPTH  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                aw_valid_i,
  input  logic                aw_ready_i,
  input  logic [ADDR_W-1:0]   aw_addr_i,
  input  logic [7:0]          aw_len_i,
  input  logic                w_valid_i,
  input  logic                w_ready_i,
  input  logic [DATA_W-1:0]   w_data_i,
  input  logic [DATA_W/8-1:0] w_strb_i,
  input  logic                w_last_i,
  output logic [7:0]          char_o,
  output logic                char_valid_o,
  input  logic                char_ready_i,
  output logic [31:0]         err_code_o,
  output logic                err_valid_o,
  output logic [31:0]         exit_code_o,
  output logic                eoc_o,
  output logic                overflow_o,
  output logic                proto_err_o
);

  localparam int c_STRB_W = DATA_W / 8;
  localparam int c_AW_PW  = $clog2(AW_DEPTH);
  localparam int c_CH_PW  = $clog2(CHAR_DEPTH);
  localparam logic [c_AW_PW:0] c_AW_FULL = (c_AW_PW + 1)'(AW_DEPTH);
  localparam logic [c_CH_PW:0] c_CH_FULL = (c_CH_PW + 1)'(CHAR_DEPTH);

  localparam logic [1:0] c_KIND_OTHER  = 2'd0;
  localparam logic [1:0] c_KIND_STDOUT = 2'd1;
  localparam logic [1:0] c_KIND_STDERR = 2'd2;
  localparam logic [1:0] c_KIND_EOC    = 2'd3;

  // AW tracking queue: {kind, len}
  logic [9:0]         r_aw_q [AW_DEPTH];
  logic [c_AW_PW-1:0] r_aw_wr, r_aw_rd;
  logic [c_AW_PW:0]   r_aw_cnt;
  logic [7:0]         r_beat_cnt;

  logic [7:0]         r_ch_mem [CHAR_DEPTH];
  logic [c_CH_PW-1:0] r_ch_wr, r_ch_rd;
  logic [c_CH_PW:0]   r_ch_cnt;

  logic [31:0] r_err_code, r_exit_code;
  logic        r_err_valid, r_eoc, r_overflow, r_proto_err;

  logic       w_aw_hs, w_w_hs;
  logic [1:0] w_aw_kind, w_cur_kind;
  logic [7:0] w_cur_len;
  logic [9:0] w_head;
  logic       w_q_empty, w_aw_full, w_beat_ok, w_orphan, w_len_hit, w_burst_end;
  logic       w_aw_pop, w_aw_push, w_aw_push_ok, w_aw_drop;
  logic       w_ch_empty, w_ch_full, w_ch_pop, w_ch_push, w_ch_push_ok, w_ch_drop;
  logic [7:0] w_char;
  logic       w_char_found;
  logic       w_first_beat;

  assign w_aw_hs = aw_valid_i && aw_ready_i;
  assign w_w_hs  = w_valid_i && w_ready_i;

  always_comb begin
    w_aw_kind = c_KIND_OTHER;
    if (aw_addr_i == STDOUT_ADDR)      w_aw_kind = c_KIND_STDOUT;
    else if (aw_addr_i == STDERR_ADDR) w_aw_kind = c_KIND_STDERR;
    else if (aw_addr_i == EOC_ADDR)    w_aw_kind = c_KIND_EOC;
  end

  // Empty queue with a concurrent AW: the beat belongs to the incoming burst.
  assign w_q_empty   = (r_aw_cnt == '0);
  assign w_aw_full   = (r_aw_cnt == c_AW_FULL);
  assign w_head      = r_aw_q[r_aw_rd];
  assign w_cur_kind  = w_q_empty ? w_aw_kind : w_head[9:8];
  assign w_cur_len   = w_q_empty ? aw_len_i  : w_head[7:0];
  assign w_beat_ok   = w_w_hs && (!w_q_empty || w_aw_hs);
  assign w_orphan    = w_w_hs && w_q_empty && !w_aw_hs;
  assign w_len_hit   = (r_beat_cnt == w_cur_len);
  assign w_burst_end = w_beat_ok && (w_last_i || w_len_hit);
  assign w_first_beat = (r_beat_cnt == 8'd0);

  assign w_aw_pop     = w_burst_end && !w_q_empty;
  assign w_aw_push    = w_aw_hs && !(w_q_empty && w_burst_end);
  assign w_aw_push_ok = w_aw_push && (!w_aw_full || w_aw_pop);
  assign w_aw_drop    = w_aw_push && !w_aw_push_ok;

  always_comb begin
    w_char       = 8'h00;
    w_char_found = 1'b0;
    for (int i = 0; i < c_STRB_W; i++) begin
      if (w_strb_i[i] && !w_char_found) begin
        w_char       = w_data_i[8*i +: 8];
        w_char_found = 1'b1;
      end
    end
  end

  assign w_ch_empty   = (r_ch_cnt == '0);
  assign w_ch_full    = (r_ch_cnt == c_CH_FULL);
  assign w_ch_pop     = char_ready_i && !w_ch_empty;
  assign w_ch_push    = w_beat_ok && (w_cur_kind == c_KIND_STDOUT) &&
                        w_char_found && (w_char != 8'h00);
  assign w_ch_push_ok = w_ch_push && (!w_ch_full || w_ch_pop);
  assign w_ch_drop    = w_ch_push && !w_ch_push_ok;

  always_ff @(posedge clk_i) begin
    if (w_aw_push_ok) r_aw_q[r_aw_wr]   <= {w_aw_kind, aw_len_i};
    if (w_ch_push_ok) r_ch_mem[r_ch_wr] <= w_char;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_aw_wr     <= '0;
      r_aw_rd     <= '0;
      r_aw_cnt    <= '0;
      r_beat_cnt  <= '0;
      r_ch_wr     <= '0;
      r_ch_rd     <= '0;
      r_ch_cnt    <= '0;
      r_err_code  <= '0;
      r_exit_code <= '0;
      r_err_valid <= 1'b0;
      r_eoc       <= 1'b0;
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_aw_push_ok) r_aw_wr <= r_aw_wr + 1'b1;
      if (w_aw_pop)     r_aw_rd <= r_aw_rd + 1'b1;
      case ({w_aw_push_ok, w_aw_pop})
        2'b10:   r_aw_cnt <= r_aw_cnt + 1'b1;
        2'b01:   r_aw_cnt <= r_aw_cnt - 1'b1;
        default: r_aw_cnt <= r_aw_cnt;
      endcase

      if (w_beat_ok) r_beat_cnt <= w_burst_end ? 8'd0 : r_beat_cnt + 8'd1;

      if (w_ch_push_ok) r_ch_wr <= r_ch_wr + 1'b1;
      if (w_ch_pop)     r_ch_rd <= r_ch_rd + 1'b1;
      case ({w_ch_push_ok, w_ch_pop})
        2'b10:   r_ch_cnt <= r_ch_cnt + 1'b1;
        2'b01:   r_ch_cnt <= r_ch_cnt - 1'b1;
        default: r_ch_cnt <= r_ch_cnt;
      endcase

      if (w_beat_ok && w_first_beat && (w_cur_kind == c_KIND_STDERR)) begin
        r_err_code  <= w_data_i[31:0];
        r_err_valid <= 1'b1;
      end
      if (w_beat_ok && w_first_beat && (w_cur_kind == c_KIND_EOC)) begin
        r_exit_code <= w_data_i[31:0];
        if (w_data_i[31:0] != 32'd0) r_eoc <= 1'b1;
      end

      if (w_aw_drop || w_ch_drop) r_overflow <= 1'b1;
      if (w_orphan || (w_beat_ok && (w_last_i != w_len_hit))) r_proto_err <= 1'b1;
    end
  end

  assign char_valid_o = !w_ch_empty;
  assign char_o       = w_ch_empty ? 8'h00 : r_ch_mem[r_ch_rd];
  assign err_code_o   = r_err_code;
  assign err_valid_o  = r_err_valid;
  assign exit_code_o  = r_exit_code;
  assign eoc_o        = r_eoc;
  assign overflow_o   = r_overflow;
  assign proto_err_o  = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_axi_print_monitor.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_axi_print_monitor                                          |
// | Purpose  : Directed self-checking bench for axi_print_monitor.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_axi_print_monitor;

  localparam logic [31:0] c_STDERR = 32'h2FFF_0000;
  localparam logic [31:0] c_STDOUT = 32'h2FFF_0004;
  localparam logic [31:0] c_EOC    = 32'h2C03_0000;
  localparam logic [31:0] c_OTHER  = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aw_valid = 1'b0, aw_ready = 1'b0;
  logic [31:0] aw_addr = '0;
  logic [7:0]  aw_len = '0;
  logic        w_valid = 1'b0, w_ready = 1'b0, w_last = 1'b0;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = '0;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready = 1'b0;
  logic [31:0] err_code, exit_code;
  logic        err_valid, eoc, overflow, proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_print_monitor dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .aw_valid_i   (aw_valid),
    .aw_ready_i   (aw_ready),
    .aw_addr_i    (aw_addr),
    .aw_len_i     (aw_len),
    .w_valid_i    (w_valid),
    .w_ready_i    (w_ready),
    .w_data_i     (w_data),
    .w_strb_i     (w_strb),
    .w_last_i     (w_last),
    .char_o       (char_out),
    .char_valid_o (char_valid),
    .char_ready_i (char_ready),
    .err_code_o   (err_code),
    .err_valid_o  (err_valid),
    .exit_code_o  (exit_code),
    .eoc_o        (eoc),
    .overflow_o   (overflow),
    .proto_err_o  (proto_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // One bus cycle starting and ending on a falling edge.
  task automatic drive(input logic aw, input logic [31:0] addr, input logic [7:0] len,
                       input logic w, input logic [31:0] data, input logic [3:0] strb,
                       input logic last);
    aw_valid = aw; aw_ready = aw; aw_addr = addr; aw_len = len;
    w_valid = w; w_ready = w; w_data = data; w_strb = strb; w_last = last;
    @(negedge clk);
    aw_valid = 1'b0; aw_ready = 1'b0; w_valid = 1'b0; w_ready = 1'b0; w_last = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    char_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({char_valid, err_valid, eoc, overflow, proto_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {char_valid, err_valid, eoc, overflow, proto_err});
    end
    checks++;
    if (err_code !== 32'd0 || exit_code !== 32'd0 || char_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: got err=%h exit=%h char=%h expected zeros",
               err_code, exit_code, char_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_char();
    apply_reset();
    drive(1'b1, c_STDOUT, 8'd0, 1'b0, 32'd0, 4'h0, 1'b0);
    drive(1'b0, 32'd0, 8'd0, 1'b1, 32'h0000_0041, 4'hF, 1'b1);
    checks++;
    if (char_valid !== 1'b1 || char_out !== 8'h41) begin
      errors++;
      $display("FAIL single_char: got valid=%b char=%h expected valid=1 char=41",
               char_valid, char_out);
    end
    checks++;
    if ({overflow, proto_err, err_valid, eoc} !== 4'b0) begin
      errors++;
      $display("FAIL single_char_flags: got %b expected 0000",
               {overflow, proto_err, err_valid, eoc});
    end
  endtask

  task automatic test_ordering();
    apply_reset();
    drive(1'b1, c_OTHER, 8'd3, 1'b0, 32'd0, 4'h0, 1'b0);
    drive(1'b1, c_STDOUT, 8'd0, 1'b0, 32'd0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      drive(1'b0, 32'd0, 8'd0, 1'b1, 32'h0000_0005, 4'hF, (i == 3));
    checks++;
    if (char_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_other_ignored: got valid=%b expected 0", char_valid);
    end
    drive(1'b0, 32'd0, 8'd0, 1'b1, 32'h0000_0048, 4'hF, 1'b1);
    checks++;
    if (char_valid !== 1'b1 || char_out !== 8'h48 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL order_char: got valid=%b char=%h perr=%b expected 1 48 0",
               char_valid, char_out, proto_err);
    end
    char_ready = 1'b1;
    @(negedge clk);
    char_ready = 1'b0;
    checks++;
    if (char_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_one_char: got valid=%b expected 0", char_valid);
    end
  endtask

  task automatic test_strobes();
    apply_reset();
    drive(1'b1, c_STDOUT, 8'd0, 1'b1, 32'h0043_0000, 4'b0100, 1'b1);
    checks++;
    if (char_valid !== 1'b1 || char_out !== 8'h43) begin
      errors++;
      $display("FAIL strobe_lane: got valid=%b char=%h expected 1 43", char_valid, char_out);
    end
    char_ready = 1'b1;
    drive(1'b1, c_STDOUT, 8'd0, 1'b1, 32'h4444_4400, 4'b0001, 1'b1);
    drive(1'b1, c_STDOUT, 8'd0, 1'b1, 32'h4444_4444, 4'b0000, 1'b1);
    char_ready = 1'b0;
    checks++;
    if (char_valid !== 1'b0) begin
      errors++;
      $display("FAIL strobe_no_push: got valid=%b expected 0", char_valid);
    end
  endtask

  task automatic test_stderr();
    apply_reset();
    drive(1'b1, c_STDERR, 8'd0, 1'b1, 32'h0000_0003, 4'hF, 1'b1);
    checks++;
    if (err_code !== 32'd3 || err_valid !== 1'b1) begin
      errors++;
      $display("FAIL stderr_bypass: got code=%h valid=%b expected 3 1", err_code, err_valid);
    end
    drive(1'b1, c_STDERR, 8'd1, 1'b1, 32'h0000_0005, 4'hF, 1'b0);
    drive(1'b0, 32'd0, 8'd0, 1'b1, 32'h0000_0007, 4'hF, 1'b1);
    checks++;
    if (err_code !== 32'd5 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL stderr_beat0: got code=%h perr=%b expected 5 0", err_code, proto_err);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 20; i++)
      drive(1'b1, c_STDOUT, 8'd0, 1'b1, 32'h61 + i, 4'hF, 1'b1);
    checks++;
    if (overflow !== 1'b1 || char_valid !== 1'b1) begin
      errors++;
      $display("FAIL char_overflow: got ovf=%b valid=%b expected 1 1", overflow, char_valid);
    end
    char_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (char_valid !== 1'b1 || char_out !== 8'(8'h61 + i)) begin
        errors++;
        $display("FAIL drain_%0d: got valid=%b char=%h expected 1 %h",
                 i, char_valid, char_out, 8'(8'h61 + i));
      end
      @(negedge clk);
    end
    char_ready = 1'b0;
    checks++;
    if (char_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got valid=%b expected 0", char_valid);
    end
  endtask

  task automatic test_aw_overflow();
    apply_reset();
    for (int i = 0; i < 8; i++)
      drive(1'b1, c_OTHER, 8'd0, 1'b0, 32'd0, 4'h0, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL aw_fill: got ovf=%b expected 0", overflow);
    end
    drive(1'b1, c_OTHER, 8'd0, 1'b0, 32'd0, 4'h0, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL aw_overflow: got ovf=%b expected 1", overflow);
    end
  endtask

  task automatic test_proto_eoc();
    apply_reset();
    drive(1'b0, 32'd0, 8'd0, 1'b1, 32'h0000_0041, 4'hF, 1'b1);
    checks++;
    if (proto_err !== 1'b1 || char_valid !== 1'b0) begin
      errors++;
      $display("FAIL orphan_beat: got perr=%b valid=%b expected 1 0", proto_err, char_valid);
    end
    drive(1'b1, c_EOC, 8'd0, 1'b1, 32'h0000_0000, 4'hF, 1'b1);
    checks++;
    if (eoc !== 1'b0) begin
      errors++;
      $display("FAIL eoc_zero: got eoc=%b expected 0", eoc);
    end
    drive(1'b1, c_EOC, 8'd0, 1'b1, 32'h0000_0001, 4'hF, 1'b1);
    checks++;
    if (exit_code !== 32'd1 || eoc !== 1'b1) begin
      errors++;
      $display("FAIL eoc_set: got code=%h eoc=%b expected 1 1", exit_code, eoc);
    end
  endtask

  task automatic test_len_mismatch();
    apply_reset();
    drive(1'b1, c_STDOUT, 8'd1, 1'b1, 32'h0000_0031, 4'hF, 1'b1);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL len_mismatch: got perr=%b expected 1", proto_err);
    end
    char_ready = 1'b1;
    @(negedge clk);
    char_ready = 1'b0;
    drive(1'b0, 32'd0, 8'd0, 1'b1, 32'h0000_005A, 4'hF, 1'b1);
    checks++;
    if (char_valid !== 1'b0) begin
      errors++;
      $display("FAIL len_mismatch_pop: got valid=%b expected 0", char_valid);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(1'b0, 32'd0, 8'd0, 1'b1, 32'd0, 4'hF, 1'b1);
    drive(1'b1, c_STDOUT, 8'd0, 1'b1, 32'h0000_0061, 4'hF, 1'b1);
    drive(1'b1, c_STDOUT, 8'd0, 1'b1, 32'h0000_0062, 4'hF, 1'b1);
    drive(1'b1, c_STDOUT, 8'd3, 1'b1, 32'h0000_0063, 4'hF, 1'b0);
    checks++;
    if (char_valid !== 1'b1 || proto_err !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got valid=%b perr=%b expected 1 1", char_valid, proto_err);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({char_valid, proto_err, overflow, err_valid, eoc} !== 5'b0 || char_out !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: got flags=%b char=%h expected 00000 00",
               {char_valid, proto_err, overflow, err_valid, eoc}, char_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(1'b0, 32'd0, 8'd0, 1'b1, 32'h0000_0064, 4'hF, 1'b1);
    checks++;
    if (proto_err !== 1'b1 || char_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: got perr=%b valid=%b expected 1 0", proto_err, char_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_ordering();
    test_strobes();
    test_stderr();
    test_overflow();
    test_aw_overflow();
    test_proto_eoc();
    test_len_mismatch();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
